// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: walks READ/LOAD/SEND per pixel, then holds IDLE for at least T_IDLE cycles between frames.
// Latency: frame starts on the falling edge after idle completes with enable (and pending trigger); all outputs registered.
// Backpressure: none; enable (and trigger when LEDSEQ_TRIGGER_EN is defined) only gate frame starts, a running frame always finishes.
module led_frame_sequencer #(
    parameter int NUM_PIXELS      = 64,
    parameter int BITS_PER_PIXEL  = 24,
    parameter int CYCLES_PER_BIT  = 15,
    parameter int FRAME_CYCLES    = 375000,
    parameter int MIN_IDLE_CYCLES = 3600,
    parameter int FRAME_W         = 5,
    parameter int SCAN_UP         = 0,
    localparam int PIX_W          = $clog2(NUM_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
`ifdef LEDSEQ_TRIGGER_EN
    input  logic               trigger,
`endif
    output logic               load_sreg,
    output logic               transmit_pixel,
    output logic [PIX_W-1:0]   pixel,
    output logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               frame_done
);

    localparam int T_SEND = BITS_PER_PIXEL * CYCLES_PER_BIT;
    localparam int T_PIX  = T_SEND + 2;
    localparam int T_ACT  = NUM_PIXELS * T_PIX;
`ifdef LEDSEQ_TRIGGER_EN
    localparam int T_IDLE = MIN_IDLE_CYCLES;
`else
    localparam int T_IDLE = (FRAME_CYCLES - T_ACT > MIN_IDLE_CYCLES) ?
                            (FRAME_CYCLES - T_ACT) : MIN_IDLE_CYCLES;
`endif
    localparam int IDLE_W = $clog2(T_IDLE + 1);
    localparam int SEND_W = (T_SEND > 1) ? $clog2(T_SEND) : 1;

    localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(T_IDLE);
    localparam logic [SEND_W-1:0] SEND_LAST = SEND_W'(T_SEND - 1);
    localparam logic [PIX_W-1:0]  PIX_START = (SCAN_UP != 0) ? PIX_W'(0) : PIX_W'(NUM_PIXELS - 1);
    localparam logic [PIX_W-1:0]  PIX_END   = (SCAN_UP != 0) ? PIX_W'(NUM_PIXELS - 1) : PIX_W'(0);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [SEND_W-1:0] bit_cnt;
    logic              idle_done;
    logic              start_ok;
    logic              start_frame;

    assign idle_done   = (idle_cnt == IDLE_DONE);
    assign start_frame = (state == IDLE) && idle_done && enable && start_ok;

`ifdef LEDSEQ_TRIGGER_EN
    logic trig_pend;

    // A trigger landing on the frame-start edge becomes the next pending request.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            trig_pend <= 1'b0;
        else if (start_frame)
            trig_pend <= trigger;
        else if (trigger)
            trig_pend <= 1'b1;
    end

    assign start_ok = trig_pend;
`else
    assign start_ok = 1'b1;
`endif

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idle_cnt       <= IDLE_DONE;
            bit_cnt        <= '0;
            pixel          <= PIX_START;
            frame          <= '0;
            load_sreg      <= 1'b0;
            transmit_pixel <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state <= READ;
                        pixel <= PIX_START;
                        busy  <= 1'b1;
                    end else if (!idle_done) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                READ: begin
                    state     <= LOAD;
                    load_sreg <= 1'b1;
                end
                LOAD: begin
                    state          <= SEND;
                    load_sreg      <= 1'b0;
                    transmit_pixel <= 1'b1;
                    bit_cnt        <= '0;
                end
                SEND: begin
                    if (bit_cnt == SEND_LAST) begin
                        transmit_pixel <= 1'b0;
                        if (pixel == PIX_END) begin
                            // The first idle cycle already counts toward the gap.
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            frame      <= frame + 1'b1;
                            idle_cnt   <= IDLE_W'(1);
                        end else begin
                            state <= READ;
                            pixel <= (SCAN_UP != 0) ? pixel + 1'b1 : pixel - 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Parametrised frame sequencer for serial addressable-LED chains; the next generation of the fixed 64-pixel matrix controller. It walks a configurable number of pixels, pulses `load_sreg` and then holds `transmit_pixel` for one pixel-time per pixel, and enforces a frame period with a guaranteed minimum latch/idle gap. It sits between the pixel-colour source (indexed by `pixel`/`frame`) and the bit-serialiser shift register. It adds enable gating, selectable scan direction, busy/frame-done status and optional external triggering.

## Interface
- `NUM_PIXELS`, 64: pixels per frame, ≥2
- `BITS_PER_PIXEL`, 24: bits shifted per pixel
- `CYCLES_PER_BIT`, 15: clk cycles per serial bit
- `FRAME_CYCLES`, 375000: target frame period in clk cycles
- `MIN_IDLE_CYCLES`, 3600: minimum idle gap between frames, ≥1
- `FRAME_W`, 5: width of the frame counter
- `SCAN_UP`, 0: 0 = pixels NUM_PIXELS-1 down to 0; 1 = 0 up to NUM_PIXELS-1
- `clk`  in  1  system clock; all registers update on the falling edge
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  allow new frames to start
- `trigger`  in  1  frame request pulse (only with `LEDSEQ_TRIGGER_EN`)
- `load_sreg`  out  1  load shift register with current pixel colour
- `transmit_pixel`  out  1  serialiser shifts while high
- `pixel`  out  PIX_W = $clog2(NUM_PIXELS)  current pixel index
- `frame`  out  FRAME_W  frame number
- `busy`  out  1  high from first READ through last SEND cycle of a frame
- `frame_done`  out  1  one-cycle pulse after the last pixel completes

## Operation
- Derived: T_PIX = BITS_PER_PIXEL*CYCLES_PER_BIT + 2; T_ACT = NUM_PIXELS*T_PIX; T_IDLE = max(FRAME_CYCLES − T_ACT, MIN_IDLE_CYCLES).
- States: IDLE, READ, LOAD, SEND. Per pixel: READ 1 cycle, LOAD 1 cycle, SEND BITS_PER_PIXEL*CYCLES_PER_BIT cycles.
- SEND last cycle: if last pixel → IDLE, else → READ with `pixel` stepped by ±1 per SCAN_UP.
- IDLE counts cycles; idle is complete once the counter reaches T_IDLE. With idle complete and `enable` high → READ, `pixel` = start index (NUM_PIXELS-1 or 0). Otherwise stay in IDLE; the counter saturates.
- `enable` is sampled only at that IDLE exit. Deasserting it mid-frame lets the frame finish.
- `frame` increments, mod 2^FRAME_W, on the cycle `frame_done` pulses. It is constant for the whole transmission.
- `load_sreg` = (state==LOAD); `transmit_pixel` = (state==SEND); `busy` = (state!=IDLE). All outputs are registered or decoded from state only, so they are glitch-free.
- Non-power-of-two NUM_PIXELS: `pixel` never leaves [0, NUM_PIXELS-1].

## Timing
- Reset (async assert, sync release): state IDLE with idle complete, `pixel` = start index, `frame`=0, `load_sreg`=`transmit_pixel`=`busy`=`frame_done`=0.
- The first frame starts on the first falling edge after `rst_n` release where `enable`=1 (no initial idle wait).
- `pixel` is valid in READ and held until the edge that ends SEND. The colour source has 1 cycle (READ) to present data before LOAD.
- `frame_done` is high in the first IDLE cycle of each gap.
- Free-running period = T_ACT + T_IDLE. If FRAME_CYCLES < T_ACT + MIN_IDLE_CYCLES, the period stretches (overrun) with no error flag.
- Counter widths are sized by $clog2 of their maxima. There is no truncation.
- `rst_n` asserted mid-frame aborts at once: outputs go to reset values, with no `frame_done` and no `frame` increment.

## Configuration
- `LEDSEQ_TRIGGER_EN` defined: `trigger` port exists. A frame starts only when idle is complete, `enable`=1, and a trigger is pending. FRAME_CYCLES is ignored, so T_IDLE = MIN_IDLE_CYCLES.
  - Trigger pulses are latched into a one-deep pending flag; further pulses while pending are dropped.
  - The flag clears on entry to READ. A trigger arriving in that same cycle is kept as new pending.
  - The flag resets to 0.
- Not defined: no `trigger` port; free-running as above.

## Test plan
Parameters for all scenarios: NUM_PIXELS=4, BITS=2, CPB=3 (T_PIX=8, T_ACT=32), FRAME_CYCLES=50, MIN_IDLE=10.
- Release reset with enable=1, SCAN_UP=0 → `pixel` sequence 3,2,1,0; `load_sreg` high at cycles 1,9,17,25; `transmit_pixel` high 6 cycles each; `frame_done` at cycle 32; next READ at cycle 50; `frame`=1.
- SCAN_UP=1, NUM_PIXELS=3 → `pixel` 0,1,2 only, never 3.
- FRAME_CYCLES=20 → period 42 (T_IDLE=10).
- enable low at cycle 10 → frame 0 completes, `frame_done` fires, then stays IDLE with `busy`=0; raising enable later starts a frame within 1 cycle.
- rst_n low at cycle 20 → all outputs 0 immediately, `frame`=0, `pixel`=3; restarts cleanly.
- With LEDSEQ_TRIGGER_EN: two triggers during frame → exactly one further frame, starting 10 cycles after `frame_done`; no trigger → stays IDLE.
